truth_table_sweeper: RTL and testbench

//  Sequential stimulus/capture stage placed directly upstream of an N-input combinational design under test.
//  On start, it drives every input combination 0..2^N-1 in ascending order and holds each one for HOLD cycles.
//  It samples the DUT output at the end of each hold window and packs the samples into a truth-table word.

---
 rtl/truth_table_sweeper_if.sv | 22 ++
 rtl/truth_table_sweeper.sv | 132 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the truth-table sweeper and its controller.
// Carries the optional expected-table input when SWEEP_CHECK_EN is defined.
interface truth_table_sweeper_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic                 f_in;
   logic [N_IN-1:0]      x_out;
   logic                 busy;
   logic                 done;
   logic [2**N_IN-1:0]   table_out;
   logic                 mismatch;
`ifdef SWEEP_CHECK_EN
   logic [2**N_IN-1:0]   expected;

   modport master (output start, f_in, expected, input x_out, busy, done, table_out, mismatch);
   modport slave  (input start, f_in, expected, output x_out, busy, done, table_out, mismatch);
`else
   modport master (output start, f_in, input x_out, busy, done, table_out, mismatch);
   modport slave  (input start, f_in, output x_out, busy, done, table_out, mismatch);
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Clocked sweep of all 2**N_IN input combinations, capturing f_in into a truth table.
// Optional table comparison against bus.expected is enabled by defining SWEEP_CHECK_EN.
module truth_table_sweeper #(
   parameter int N_IN = 3,
   parameter int HOLD = 20
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);
   localparam int TBL_W  = 2**N_IN;
   localparam int HOLD_W = $clog2(HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
   localparam logic [N_IN-1:0]   IDX_LAST  = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              state_r,    state_s;
   logic [N_IN-1:0]     idx_r,      idx_s;
   logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
   logic [N_IN-1:0]     x_out_r,    x_out_s;
   logic                busy_r,     busy_s;
   logic                done_r,     done_s;
   logic [TBL_W-1:0]    table_r,    table_s;
   logic                mismatch_r, mismatch_s;
   logic [TBL_W-1:0]    captured_s;

   function automatic logic [TBL_W-1:0] set_bit(input logic [TBL_W-1:0] tbl,
                                                input logic [N_IN-1:0]  pos,
                                                input logic             val);
      logic [TBL_W-1:0] res;
      res      = tbl;
      res[pos] = val;
      return res;
   endfunction

   // Next-state and next-output logic for the sweep FSM
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      hold_cnt_s = hold_cnt_r;
      x_out_s    = x_out_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      table_s    = table_r;
      mismatch_s = mismatch_r;
      captured_s = set_bit(table_r, idx_r, bus.f_in);

      case (state_r)
         S_IDLE: begin
            if (bus.start) begin
               state_s    = S_DRIVE;
               idx_s      = {N_IN{1'b0}};
               hold_cnt_s = {HOLD_W{1'b0}};
               x_out_s    = {N_IN{1'b0}};
               busy_s     = 1'b1;
               table_s    = {TBL_W{1'b0}};
               mismatch_s = 1'b0;
            end else begin
               state_s = S_IDLE;
               busy_s  = 1'b0;
            end
         end
         S_DRIVE: begin
            busy_s = 1'b1;
            if (hold_cnt_r == HOLD_LAST) begin
               // End of hold window: the capture includes this cycle's f_in
               table_s    = captured_s;
               hold_cnt_s = {HOLD_W{1'b0}};
               if (idx_r == IDX_LAST) begin
                  state_s = S_DONE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  x_out_s = {N_IN{1'b0}};
`ifdef SWEEP_CHECK_EN
                  mismatch_s = (captured_s != bus.expected);
`else
                  mismatch_s = 1'b0;
`endif
               end else begin
                  idx_s   = idx_r + N_IN'(1);
                  x_out_s = idx_r + N_IN'(1);
               end
            end else begin
               hold_cnt_s = hold_cnt_r + HOLD_W'(1);
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = S_IDLE;
            busy_s  = 1'b0;
            x_out_s = {N_IN{1'b0}};
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         idx_r      <= {N_IN{1'b0}};
         hold_cnt_r <= {HOLD_W{1'b0}};
         x_out_r    <= {N_IN{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         table_r    <= {TBL_W{1'b0}};
         mismatch_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         hold_cnt_r <= hold_cnt_s;
         x_out_r    <= x_out_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         table_r    <= table_s;
         mismatch_r <= mismatch_s;
      end
   end

   assign bus.x_out     = x_out_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.table_out = table_r;
   assign bus.mismatch  = mismatch_r;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: HOLD=20 sweeps (directed + randomized) and a HOLD=1 vector table.
// Expected behaviour comes from cycle arithmetic on the sweep rules, not from the RTL structure.
module tb_truth_table_sweeper;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   truth_table_sweeper_if #(.N_IN(3)) ifa ();
   truth_table_sweeper_if #(.N_IN(3)) ifb ();

   truth_table_sweeper #(.N_IN(3), .HOLD(20)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   truth_table_sweeper #(.N_IN(3), .HOLD(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   logic [7:0] tt_a;
   logic [7:0] tt_b;
   logic       comb_a;
   logic       fdrv_a;

   // Modelled combinational DUTs; dut_a can instead see noise outside the capture cycle
   assign ifa.f_in = comb_a ? tt_a[ifa.x_out] : fdrv_a;
   assign ifb.f_in = tt_b[ifb.x_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] f_tt;
      logic [7:0] exp_in;
      logic [7:0] exp_tbl;
      logic       exp_mm;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] low_mask(input int n);
      logic [8:0] m;
      m = (9'd1 << n) - 9'd1;
      return m[7:0];
   endfunction

   function automatic logic model_mm(input logic [7:0] tbl, input logic [7:0] exp_in);
`ifdef SWEEP_CHECK_EN
      return (tbl != exp_in);
`else
      return 1'b0;
`endif
   endfunction

   // One HOLD=20 sweep; j counts edges after the start-sampling edge E0
   task automatic sweep_a(input logic [7:0] tt, input logic [7:0] exp_in, input bit noise,
                          input int poke_at, input int abort_at, input bit keep_start);
      int         n;
      logic [7:0] e_x, e_tbl;
      logic       e_busy, e_done, e_mm;
      tt_a   = tt;
      comb_a = !noise;
      fdrv_a = 1'b0;
`ifdef SWEEP_CHECK_EN
      ifa.expected = exp_in;
`endif
      ifa.start = 1'b1;
      @(posedge clk);
      for (int j = 0; j <= 161; j++) begin
         @(negedge clk);
         if (j == 0 && !keep_start) ifa.start = 1'b0;
         if (j == poke_at) ifa.start = 1'b1;
         else if (j == poke_at + 1 && !keep_start) ifa.start = 1'b0;
         if (j == abort_at) begin
            ifa.start = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("rst_x_out", {5'd0, ifa.x_out}, 8'd0);
            chk("rst_busy", {7'd0, ifa.busy}, 8'd0);
            chk("rst_done", {7'd0, ifa.done}, 8'd0);
            chk("rst_table", ifa.table_out, 8'd0);
            chk("rst_mismatch", {7'd0, ifa.mismatch}, 8'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("post_rst_idle_busy", {7'd0, ifa.busy}, 8'd0);
            chk("post_rst_x_out", {5'd0, ifa.x_out}, 8'd0);
            chk("post_rst_table", ifa.table_out, 8'd0);
            return;
         end
         if (j < 160) begin
            n      = j / 20;
            e_x    = 8'(n);
            e_busy = 1'b1;
            e_done = 1'b0;
            e_tbl  = tt & low_mask(n);
            e_mm   = 1'b0;
            fdrv_a = (j % 20 == 19) ? tt[n] : 1'($urandom_range(0, 1));
         end else begin
            e_x    = 8'd0;
            e_busy = 1'b0;
            e_done = (j == 160);
            e_tbl  = tt;
            e_mm   = model_mm(tt, exp_in);
         end
         chk("a_x_out", {5'd0, ifa.x_out}, e_x);
         chk("a_busy", {7'd0, ifa.busy}, {7'd0, e_busy});
         chk("a_done", {7'd0, ifa.done}, {7'd0, e_done});
         chk("a_table", ifa.table_out, e_tbl);
         chk("a_mismatch", {7'd0, ifa.mismatch}, {7'd0, e_mm});
      end
      if (!keep_start) ifa.start = 1'b0;
   endtask

   // One HOLD=1 sweep: x_out steps every cycle, done 9 cycles after start
   task automatic sweep_b(input vec_t v);
      logic [7:0] e_x, e_tbl;
      logic       e_mm;
      tt_b = v.f_tt;
`ifdef SWEEP_CHECK_EN
      ifb.expected = v.exp_in;
      e_mm = v.exp_mm;
`else
      e_mm = 1'b0;
`endif
      ifb.start = 1'b1;
      @(posedge clk);
      for (int j = 0; j <= 9; j++) begin
         @(negedge clk);
         ifb.start = 1'b0;
         e_x   = (j < 8) ? 8'(j) : 8'd0;
         e_tbl = (j < 8) ? (v.exp_tbl & low_mask(j)) : v.exp_tbl;
         chk("b_x_out", {5'd0, ifb.x_out}, e_x);
         chk("b_busy", {7'd0, ifb.busy}, (j < 8) ? 8'd1 : 8'd0);
         chk("b_done", {7'd0, ifb.done}, (j == 8) ? 8'd1 : 8'd0);
         chk("b_table", ifb.table_out, e_tbl);
         chk("b_mismatch", {7'd0, ifb.mismatch}, (j >= 8) ? {7'd0, e_mm} : 8'd0);
      end
   endtask

   initial begin
      logic [7:0] rt, re;
      vec_t       rv;
      total = 0;
      bad   = 0;
      vecs[0] = '{f_tt: 8'h96, exp_in: 8'h96, exp_tbl: 8'h96, exp_mm: 1'b0};
      vecs[1] = '{f_tt: 8'hEA, exp_in: 8'hEB, exp_tbl: 8'hEA, exp_mm: 1'b1};
      vecs[2] = '{f_tt: 8'h00, exp_in: 8'h00, exp_tbl: 8'h00, exp_mm: 1'b0};
      vecs[3] = '{f_tt: 8'hFF, exp_in: 8'hFE, exp_tbl: 8'hFF, exp_mm: 1'b1};
      vecs[4] = '{f_tt: 8'h01, exp_in: 8'h01, exp_tbl: 8'h01, exp_mm: 1'b0};
      vecs[5] = '{f_tt: 8'h80, exp_in: 8'h00, exp_tbl: 8'h80, exp_mm: 1'b1};

      rst_n     = 1'b0;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      tt_a      = 8'h00;
      tt_b      = 8'h00;
      comb_a    = 1'b1;
      fdrv_a    = 1'b0;
`ifdef SWEEP_CHECK_EN
      ifa.expected = 8'h00;
      ifb.expected = 8'h00;
`endif
      #12;
      chk("reset_x_out", {5'd0, ifa.x_out}, 8'd0);
      chk("reset_busy", {7'd0, ifa.busy}, 8'd0);
      chk("reset_done", {7'd0, ifa.done}, 8'd0);
      chk("reset_table", ifa.table_out, 8'd0);
      chk("reset_mismatch", {7'd0, ifa.mismatch}, 8'd0);
      chk("reset_b_table", ifb.table_out, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", {7'd0, ifa.busy}, 8'd0);

      // Full sweep of (x1&x2)|x3, restart poke at idx 3, reset at idx 4
      sweep_a(8'hEA, 8'hEA, 1'b0, -1, -1, 1'b0);
      sweep_a(8'hEA, 8'hEB, 1'b0, 65, -1, 1'b0);
      sweep_a(8'hEA, 8'hEA, 1'b0, -1, 85, 1'b0);

      // Back-to-back with start held high; second sweep must clear the table
      rt = 8'($urandom);
      sweep_a(8'hEA, 8'hEA, 1'b0, -1, -1, 1'b1);
      sweep_a(rt, rt, 1'b1, -1, -1, 1'b0);

      // Randomized tables with noise outside the capture cycle
      for (int r = 0; r < 3; r++) begin
         rt = 8'($urandom);
         re = ($urandom_range(0, 1) == 0) ? rt : 8'($urandom);
         sweep_a(rt, re, 1'b1, -1, -1, 1'b0);
         @(negedge clk);
      end

      for (int i = 0; i < 6; i++) begin
         sweep_b(vecs[i]);
      end
      for (int r = 0; r < 4; r++) begin
         rv.f_tt    = 8'($urandom);
         rv.exp_in  = ($urandom_range(0, 1) == 0) ? rv.f_tt : 8'($urandom);
         rv.exp_tbl = rv.f_tt;
         rv.exp_mm  = (rv.f_tt != rv.exp_in);
         sweep_b(rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
